reg_if_arbiter: RTL and testbench
=================================

Name: reg_if_arbiter

Overview:
Two-requester arbiter for the simple register interface produced by axi_lite_slave. It lets two masters share one user register bank: m0 is normally the AXI-Lite slave and m1 an internal sequencer or a second bus bridge. Arbitration is round-robin, one transaction at a time. Write/read strobes and the invalid-address flag are forwarded, and responses are routed back to the winner.

Parameters:
ADDR_WIDTH, 16, register address width on all ports
TIMEOUT_WIDTH, 8, width of the bank-response watchdog counter; the timeout fires at count 2^TIMEOUT_WIDTH-1 (only with REG_ARB_TIMEOUT_EN)

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
i_mN_reg_address  in  ADDR_WIDTH  requester N address, N = 0,1 (one port per N, same for all mN lines below)
i_mN_reg_in_rdy  in  1  requester N write strobe, held high until o_mN_reg_in_ack
i_mN_reg_in_data  in  32  requester N write data
o_mN_reg_in_ack  out  1  one-cycle write-complete pulse
i_mN_reg_out_req  in  1  requester N read strobe, held high until o_mN_reg_out_rdy
o_mN_reg_out_rdy  out  1  one-cycle read-data-valid pulse
o_mN_reg_out_data  out  32  read data, valid while o_mN_reg_out_rdy=1
o_mN_reg_invalid_addr  out  1  pulses with ack/rdy if the bank flagged the address invalid
o_reg_address  out  ADDR_WIDTH  address to the register bank
o_reg_in_rdy  out  1  write strobe to the bank
o_reg_in_data  out  32  write data to the bank
i_reg_in_ack  in  1  bank write-ack pulse
o_reg_out_req  out  1  read strobe to the bank
i_reg_out_rdy  in  1  bank read-data-valid pulse
i_reg_out_data  in  32  bank read data
i_reg_invalid_addr  in  1  bank invalid-address flag, same cycle as ack/rdy
o_grant  out  2  one-hot current owner; 0 when idle
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: every output is 0; state IDLE; last_grant=1 so m0 wins the first contention; o_mN_reg_out_data=0.
- Request: requester N requests when i_mN_reg_in_rdy | i_mN_reg_out_req. If a requester asserts both, the write is served first and the read is served as a later transaction.
- IDLE:
  - One requester: grant it.
  - Both: grant the one not equal to last_grant.
  - On grant: latch address, data and direction into internal registers; set last_grant; go to BUSY next cycle.
- BUSY:
  - o_reg_address and o_reg_in_data come from the latched registers.
  - o_reg_in_rdy = busy_wr & ~i_reg_in_ack, and o_reg_out_req = busy_rd & ~i_reg_out_rdy. The strobe is gated combinationally so the bank never sees a strobe still high in its ack cycle, so no double write or read.
  - A direction-matching ack/rdy from the bank captures i_reg_out_data and i_reg_invalid_addr; go to RESP.
  - An ack of the wrong direction is ignored.
- RESP (1 cycle):
  - Pulse o_mN_reg_in_ack or o_mN_reg_out_rdy, with o_mN_reg_invalid_addr (captured value), to the owner only.
  - Drive read data for the owner; the non-owner's outputs stay 0.
  - Go to RELEASE.
- RELEASE: hold until the owner's granted strobe is low, then go to IDLE and clear o_grant. This prevents a stale level from being re-granted.
- Latency: grant to bank strobe is 1 cycle; bank ack to requester ack is 1 cycle. Minimum transaction is 4 cycles, IDLE to IDLE.
- Fairness: with both requesters continuously requesting, grants strictly alternate. Neither can win twice while the other is pending.
- Requester inputs are ignored except in IDLE (sampling) and RELEASE (strobe check).
- Reset mid-transaction: immediately returns to IDLE with all strobes and outputs 0. The in-flight transaction is dropped with no ack.

Optional Feature:
- Macro: REG_ARB_TIMEOUT_EN.
- When defined:
  - A TIMEOUT_WIDTH counter clears on entry to BUSY and increments each BUSY cycle.
  - At all-ones, the bank strobe drops and the FSM goes to RESP with invalid_addr=1 and read data 32'hDEAD_BEEF.
  - A bank ack in the same cycle as the timeout wins, and the normal response is used.
- When undefined: no counter is built, and BUSY waits indefinitely.

Test Plan:
- m0 writes 0x0000 data 0x12345678, bank acks 2 cycles later -> o_reg_in_rdy high exactly until the ack cycle; o_m0_reg_in_ack pulses once 1 cycle after the bank ack; m1 outputs stay 0.
- m0 and m1 both read (addr 0x0004, 0x0000) in the same cycle after reset -> m0 is served first, then m1; each gets its own data (0x10000000, 0x0); o_grant goes 01, 00, 10.
- m0 requests back-to-back continuously while m1 holds a write -> grants alternate m0, m1, m0; m1's write completes before m0's second transaction.
- Read addr 0x0008, bank returns invalid=1, data 0 -> o_m0_reg_invalid_addr and o_m0_reg_out_rdy pulse together with data 0.
- With REG_ARB_TIMEOUT_EN and TIMEOUT_WIDTH=4, bank never acks -> after 15 BUSY cycles the requester gets rdy, invalid=1, data 0xDEADBEEF; without the macro, o_busy stays 1.
- Assert rst during BUSY of an m1 write -> next cycle all outputs 0, state IDLE; a following m0 request is granted normally.

Source files
------------

// File: rtl/reg_if_arbiter_if.sv
// Register-interface link between one requester and one register bank.
// master drives the strobes; slave returns ack/rdy, read data and the invalid flag.
interface reg_if_arbiter_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] reg_address;
    logic                  reg_in_rdy;
    logic [31:0]           reg_in_data;
    logic                  reg_in_ack;
    logic                  reg_out_req;
    logic                  reg_out_rdy;
    logic [31:0]           reg_out_data;
    logic                  reg_invalid_addr;

    modport master (
        output reg_address,
        output reg_in_rdy,
        output reg_in_data,
        output reg_out_req,
        input  reg_in_ack,
        input  reg_out_rdy,
        input  reg_out_data,
        input  reg_invalid_addr
    );

    modport slave (
        input  reg_address,
        input  reg_in_rdy,
        input  reg_in_data,
        input  reg_out_req,
        output reg_in_ack,
        output reg_out_rdy,
        output reg_out_data,
        output reg_invalid_addr
    );
endinterface

// File: rtl/reg_if_arbiter.sv
// Round-robin arbiter letting two register-interface requesters share one bank.
// Optional bank-response watchdog enabled by defining REG_ARB_TIMEOUT_EN.
module reg_if_arbiter #(
    parameter int ADDR_WIDTH    = 16,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    reg_if_arbiter_if.slave  m0,
    reg_if_arbiter_if.slave  m1,
    reg_if_arbiter_if.master bank,
    output logic [1:0]       o_grant,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_RELEASE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                  owner;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_data;
    logic                  lat_wr;
    logic [31:0]           cap_data;
    logic                  cap_inv;

    logic                  req0;
    logic                  req1;
    logic                  grant_go;
    logic                  grant_sel;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_data;
    logic                  bank_done;
    logic                  own_strobe;
    logic                  tmo;

    assign req0     = m0.reg_in_rdy | m0.reg_out_req;
    assign req1     = m1.reg_in_rdy | m1.reg_out_req;
    assign grant_go = req0 | req1;

    // On contention the side that did not win last time gets the bank.
    assign grant_sel = (req0 & req1) ? ~last_grant : req1;

    // Writes win over reads from the same requester; the read follows later.
    assign sel_wr   = grant_sel ? m1.reg_in_rdy : m0.reg_in_rdy;
    assign sel_addr = grant_sel ? m1.reg_address : m0.reg_address;
    assign sel_data = grant_sel ? m1.reg_in_data : m0.reg_in_data;

    assign bank_done = lat_wr ? bank.reg_in_ack : bank.reg_out_rdy;

    assign own_strobe = owner
        ? (lat_wr ? m1.reg_in_rdy : m1.reg_out_req)
        : (lat_wr ? m0.reg_in_rdy : m0.reg_out_req);

`ifdef REG_ARB_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;

    // Watchdog counts BUSY cycles and restarts from zero for every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ST_BUSY) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo = (state == ST_BUSY) & (&tmo_cnt);
`else
    assign tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the granted request and capture the bank's response.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_wr     <= 1'b0;
            cap_data   <= '0;
            cap_inv    <= 1'b0;
        end else begin
            if (state == ST_IDLE && grant_go) begin
                owner      <= grant_sel;
                last_grant <= grant_sel;
                lat_addr   <= sel_addr;
                lat_data   <= sel_data;
                lat_wr     <= sel_wr;
            end
            if (state == ST_BUSY) begin
                if (bank_done) begin
                    cap_data <= bank.reg_out_data;
                    cap_inv  <= bank.reg_invalid_addr;
                end else if (tmo) begin
                    cap_data <= 32'hDEAD_BEEF;
                    cap_inv  <= 1'b1;
                end
            end
        end
    end

    // Next-state decode plus all bank- and requester-facing outputs.
    always_comb begin
        state_nxt             = state;
        bank.reg_address      = '0;
        bank.reg_in_data      = '0;
        bank.reg_in_rdy       = 1'b0;
        bank.reg_out_req      = 1'b0;
        m0.reg_in_ack         = 1'b0;
        m0.reg_out_rdy        = 1'b0;
        m0.reg_out_data       = '0;
        m0.reg_invalid_addr   = 1'b0;
        m1.reg_in_ack         = 1'b0;
        m1.reg_out_rdy        = 1'b0;
        m1.reg_out_data       = '0;
        m1.reg_invalid_addr   = 1'b0;
        o_busy                = (state != ST_IDLE);
        o_grant               = 2'b00;

        if (state != ST_IDLE) begin
            o_grant = owner ? 2'b10 : 2'b01;
        end

        unique case (state)
            ST_IDLE: begin
                if (grant_go) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                bank.reg_address = lat_addr;
                bank.reg_in_data = lat_data;
                bank.reg_in_rdy  = lat_wr & ~bank.reg_in_ack & ~tmo;
                bank.reg_out_req = ~lat_wr & ~bank.reg_out_rdy & ~tmo;
                if (bank_done | tmo) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (owner) begin
                    m1.reg_in_ack       = lat_wr;
                    m1.reg_out_rdy      = ~lat_wr;
                    m1.reg_out_data     = lat_wr ? 32'h0 : cap_data;
                    m1.reg_invalid_addr = cap_inv;
                end else begin
                    m0.reg_in_ack       = lat_wr;
                    m0.reg_out_rdy      = ~lat_wr;
                    m0.reg_out_data     = lat_wr ? 32'h0 : cap_data;
                    m0.reg_invalid_addr = cap_inv;
                end
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!own_strobe) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_if_arbiter.sv
// Directed self-checking bench for reg_if_arbiter.
// Bank responses are driven by hand; every expected value is written out below.
module tb_reg_if_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] o_grant;
    logic       o_busy;

    int n_cmp;
    int n_bad;

    reg_if_arbiter_if #(.ADDR_WIDTH(16)) m0_if ();
    reg_if_arbiter_if #(.ADDR_WIDTH(16)) m1_if ();
    reg_if_arbiter_if #(.ADDR_WIDTH(16)) bank_if ();

    reg_if_arbiter #(
        .ADDR_WIDTH    (16),
        .TIMEOUT_WIDTH (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m0      (m0_if),
        .m1      (m1_if),
        .bank    (bank_if),
        .o_grant (o_grant),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Called in the first checked BUSY cycle: acks, then follows RESP/RELEASE.
    task automatic serve(input string tag, input logic [1:0] g,
                         input logic [15:0] a, input logic wr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input logic inv);
        logic [34:0] own_rsp;
        logic [34:0] oth_rsp;
        chk({tag, "_grant"}, 64'(o_grant), 64'(g));
        chk({tag, "_busy"}, 64'(o_busy), 64'd1);
        chk({tag, "_addr"}, 64'(bank_if.reg_address), 64'(a));
        if (wr) begin
            chk({tag, "_wstb"}, 64'(bank_if.reg_in_rdy), 64'd1);
            chk({tag, "_wdat"}, 64'(bank_if.reg_in_data), 64'(wd));
            bank_if.reg_in_ack = 1'b1;
        end else begin
            chk({tag, "_rstb"}, 64'(bank_if.reg_out_req), 64'd1);
            bank_if.reg_out_rdy = 1'b1;
        end
        bank_if.reg_out_data     = rd;
        bank_if.reg_invalid_addr = inv;
        #1;
        chk({tag, "_gate"},
            64'(bank_if.reg_in_rdy | bank_if.reg_out_req), 64'd0);
        tick();
        bank_if.reg_in_ack       = 1'b0;
        bank_if.reg_out_rdy      = 1'b0;
        bank_if.reg_out_data     = 32'hFFFF_FFFF;
        bank_if.reg_invalid_addr = 1'b0;
        #1;
        own_rsp = g[1]
            ? {m1_if.reg_in_ack, m1_if.reg_out_rdy,
               m1_if.reg_invalid_addr, m1_if.reg_out_data}
            : {m0_if.reg_in_ack, m0_if.reg_out_rdy,
               m0_if.reg_invalid_addr, m0_if.reg_out_data};
        oth_rsp = g[1]
            ? {m0_if.reg_in_ack, m0_if.reg_out_rdy,
               m0_if.reg_invalid_addr, m0_if.reg_out_data}
            : {m1_if.reg_in_ack, m1_if.reg_out_rdy,
               m1_if.reg_invalid_addr, m1_if.reg_out_data};
        chk({tag, "_rsp"}, 64'(own_rsp),
            64'({wr, ~wr, inv, (wr ? 32'h0 : rd)}));
        chk({tag, "_other"}, 64'(oth_rsp), 64'd0);
        chk({tag, "_bstb"},
            64'(bank_if.reg_in_rdy | bank_if.reg_out_req), 64'd0);
        if (g[1]) begin
            if (wr) m1_if.reg_in_rdy = 1'b0;
            else    m1_if.reg_out_req = 1'b0;
        end else begin
            if (wr) m0_if.reg_in_rdy = 1'b0;
            else    m0_if.reg_out_req = 1'b0;
        end
        tick();
        chk({tag, "_rel_grant"}, 64'(o_grant), 64'(g));
        chk({tag, "_one_pulse"},
            64'(m0_if.reg_in_ack | m0_if.reg_out_rdy |
                m1_if.reg_in_ack | m1_if.reg_out_rdy), 64'd0);
        tick();
        chk({tag, "_idle_grant"}, 64'(o_grant), 64'd0);
        chk({tag, "_idle_busy"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        m0_if.reg_address   = '0;
        m0_if.reg_in_rdy    = 1'b0;
        m0_if.reg_in_data   = '0;
        m0_if.reg_out_req   = 1'b0;
        m1_if.reg_address   = '0;
        m1_if.reg_in_rdy    = 1'b0;
        m1_if.reg_in_data   = '0;
        m1_if.reg_out_req   = 1'b0;
        bank_if.reg_in_ack       = 1'b0;
        bank_if.reg_out_rdy      = 1'b0;
        bank_if.reg_out_data     = '0;
        bank_if.reg_invalid_addr = 1'b0;

        do_reset();
        chk("rst_grant", 64'(o_grant), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_bank",
            64'({bank_if.reg_in_rdy, bank_if.reg_out_req,
                 bank_if.reg_address}), 64'd0);
        chk("rst_bank_data", 64'(bank_if.reg_in_data), 64'd0);
        chk("rst_m0",
            64'({m0_if.reg_in_ack, m0_if.reg_out_rdy,
                 m0_if.reg_invalid_addr, m0_if.reg_out_data}), 64'd0);
        chk("rst_m1",
            64'({m1_if.reg_in_ack, m1_if.reg_out_rdy,
                 m1_if.reg_invalid_addr, m1_if.reg_out_data}), 64'd0);

        // m0 write, bank acks in the second BUSY cycle.
        m0_if.reg_address = 16'h0000;
        m0_if.reg_in_data = 32'h1234_5678;
        m0_if.reg_in_rdy  = 1'b1;
        tick();
        chk("wr_stb_c1", 64'(bank_if.reg_in_rdy), 64'd1);
        tick();
        serve("wr", 2'b01, 16'h0000, 1'b1, 32'h1234_5678, 32'h0, 1'b0);

        // Simultaneous reads right after reset: m0 first, then m1.
        do_reset();
        m0_if.reg_address = 16'h0004;
        m0_if.reg_out_req = 1'b1;
        m1_if.reg_address = 16'h0000;
        m1_if.reg_out_req = 1'b1;
        tick();
        serve("rd_m0", 2'b01, 16'h0004, 1'b0, 32'h0, 32'h1000_0000, 1'b0);
        tick();
        serve("rd_m1", 2'b10, 16'h0000, 1'b0, 32'h0, 32'h0, 1'b0);

        // m0 re-requests back to back while m1 holds a write.
        m0_if.reg_address = 16'h0010;
        m0_if.reg_in_data = 32'h0000_000A;
        m0_if.reg_in_rdy  = 1'b1;
        m1_if.reg_address = 16'h0020;
        m1_if.reg_in_data = 32'h0000_000B;
        m1_if.reg_in_rdy  = 1'b1;
        tick();
        serve("rr_a", 2'b01, 16'h0010, 1'b1, 32'h0000_000A, 32'h0, 1'b0);
        m0_if.reg_address = 16'h0030;
        m0_if.reg_in_data = 32'h0000_000C;
        m0_if.reg_in_rdy  = 1'b1;
        tick();
        serve("rr_b", 2'b10, 16'h0020, 1'b1, 32'h0000_000B, 32'h0, 1'b0);
        tick();
        serve("rr_c", 2'b01, 16'h0030, 1'b1, 32'h0000_000C, 32'h0, 1'b0);

        // Invalid address on a read.
        m0_if.reg_address = 16'h0008;
        m0_if.reg_out_req = 1'b1;
        tick();
        serve("inv", 2'b01, 16'h0008, 1'b0, 32'h0, 32'h0, 1'b1);

        // Write and read from one requester: write is served first.
        m1_if.reg_address = 16'h0040;
        m1_if.reg_in_data = 32'hCAFE_0001;
        m1_if.reg_in_rdy  = 1'b1;
        m1_if.reg_out_req = 1'b1;
        tick();
        serve("wr1st", 2'b10, 16'h0040, 1'b1, 32'hCAFE_0001, 32'h0, 1'b0);
        tick();
        serve("rd2nd", 2'b10, 16'h0040, 1'b0, 32'h0, 32'h8765_4321, 1'b0);

        // Bank never answers: busy holds, then reset drops the m1 write.
        m1_if.reg_address = 16'h0050;
        m1_if.reg_in_data = 32'h0000_0050;
        m1_if.reg_in_rdy  = 1'b1;
        tick();
        chk("hang_grant", 64'(o_grant), 64'd2);
        for (int i = 0; i < 20; i++) tick();
        chk("hang_busy", 64'(o_busy), 64'd1);
        chk("hang_stb", 64'(bank_if.reg_in_rdy), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_ctl", 64'({o_grant, o_busy}), 64'd0);
        chk("mid_rst_bank",
            64'({bank_if.reg_in_rdy, bank_if.reg_out_req,
                 bank_if.reg_address, bank_if.reg_in_data}), 64'd0);
        chk("mid_rst_m1",
            64'({m1_if.reg_in_ack, m1_if.reg_out_rdy,
                 m1_if.reg_invalid_addr, m1_if.reg_out_data}), 64'd0);
        rst = 1'b0;
        m1_if.reg_in_rdy  = 1'b0;
        m0_if.reg_address = 16'h0004;
        m0_if.reg_out_req = 1'b1;
        tick();
        serve("post_rst", 2'b01, 16'h0004, 1'b0, 32'h0, 32'h0000_55AA, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
